// File: rtl/soc_bus_bridge_pkg.sv
// Shared types and constants for the CPU-to-slave bus bridge.
// Holds the FSM state encoding, default address map and timeout counter width.
package soc_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int ADDR_W    = 32;
    localparam int TMO_CNT_W = 8;

    // Slot 0 in the LSBs.
    localparam logic [4*ADDR_W-1:0] DEF_SLV_BASE =
        {32'hFFFF_F060, 32'hFFFF_F070, 32'hFFFF_F000, 32'h0000_4000};
    localparam logic [4*ADDR_W-1:0] DEF_SLV_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000};

endpackage

// File: rtl/soc_bus_bridge_if.sv
// Bridge bus bundle: CPU request/response side plus the broadcast slave side.
// The master modport is the bridge, the slave modport is the CPU and slave devices.
interface soc_bus_bridge_if #(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32
);
    logic                      cpu_req;
    logic                      cpu_we;
    logic [31:0]               cpu_addr;
    logic [DATA_W-1:0]         cpu_wdata;
    logic                      cpu_ready;
    logic [DATA_W-1:0]         cpu_rdata;
    logic                      cpu_err;

    logic [NUM_SLV-1:0]        slv_sel;
    logic                      slv_we;
    logic [31:0]               slv_addr;
    logic [DATA_W-1:0]         slv_wdata;
    logic [NUM_SLV*DATA_W-1:0] slv_rdata;
    logic [NUM_SLV-1:0]        slv_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        output cpu_ready, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
        input  cpu_ready, cpu_rdata, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/soc_bus_bridge_addr_decode.sv
// Address decoder: one-hot slave hit vector (lowest index wins) and a miss flag.
// Latency: combinational.
// Backpressure: none, pure function of the address.
module bus_addr_decode
    import soc_bus_bridge_pkg::*;
#(
    parameter int                          NUM_SLV  = 4,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] hit,
    output logic               miss
);

    always_comb begin
        hit  = '0;
        miss = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (miss && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                hit[i] = 1'b1;
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/soc_bus_bridge.sv
// CPU-to-slave bus bridge: decodes a request, selects one slave, returns its response.
// Latency: hit 2 cycles minimum (req -> ack -> cpu_ready), decode miss 1 cycle.
// Backpressure: one transaction at a time; cpu_req only sampled in IDLE. Optional BRIDGE_TIMEOUT_EN aborts stalled accesses.
module soc_bus_bridge
    import soc_bus_bridge_pkg::*;
#(
    parameter int                          NUM_SLV  = 4,
    parameter int                          DATA_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK,
    parameter int                          TIMEOUT  = 15
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    soc_bus_bridge_if.master  bus
);

    state_t              state;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_SLV-1:0]  sel_q;
    logic                ready_q;
    logic                err_q;

    logic [NUM_SLV-1:0]  dec_hit;
    logic                dec_miss;
    logic                ack_hit;
    logic [DATA_W-1:0]   sel_rdata;

    bus_addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (bus.cpu_addr),
        .hit  (dec_hit),
        .miss (dec_miss)
    );

    // Masking with the registered select makes acks from other slaves invisible.
    assign ack_hit = |(bus.slv_ack & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | bus.slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic [TMO_CNT_W-1:0] tmo_next;
    logic                 tmo_hit;

    assign tmo_next = tmo_cnt + 1'b1;
    assign tmo_hit  = (tmo_next == TMO_CNT_W'(TIMEOUT));
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        we_q    <= bus.cpu_we;
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        if (dec_miss) begin
                            state   <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state <= ACCESS;
                            sel_q <= dec_hit;
`ifdef BRIDGE_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the final allowed cycle takes priority over the abort.
                    if (ack_hit) begin
                        state   <= RESP;
                        sel_q   <= '0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : sel_rdata;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state   <= RESP;
                        sel_q   <= '0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
`endif
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state   <= IDLE;
                    sel_q   <= '0;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.cpu_ready = ready_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_err   = err_q;
    assign bus.slv_sel   = sel_q;
    assign bus.slv_we    = we_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;

endmodule

// File: tb/tb_soc_bus_bridge.sv
// Randomized self-checking bench for soc_bus_bridge against a transaction-level model.
// Abort cases are exercised when BRIDGE_TIMEOUT_EN is defined.
module tb_soc_bus_bridge;

    localparam int NUM_SLV = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    localparam logic [31:0] BASE_T [0:3] = '{32'h0000_4000, 32'hFFFF_F000, 32'hFFFF_F070, 32'hFFFF_F060};
    localparam logic [31:0] MASK_T [0:3] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    logic cpu_clk;
    logic cpu_rst_n;
    int   n_chk;
    int   n_pass;

    soc_bus_bridge_if #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W)) bus ();

    soc_bus_bridge #(
        .NUM_SLV (NUM_SLV),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .bus       (bus)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference address map: first matching slot, -1 for no match.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NUM_SLV; i++)
            if ((a & MASK_T[i]) == BASE_T[i]) return i;
        return -1;
    endfunction

    task automatic drive_junk_req();
        bus.cpu_req   = 1'($urandom_range(0, 1));
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
    endtask

    // Entered and left on a negedge with the DUT in IDLE. dly = ACCESS cycles before ack.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd, input logic stray);
        int          idx;
        int          n_acc;
        logic        err_e;
        logic [3:0]  own;
        idx = ref_decode(a);
        chk("idle_ready", bus.cpu_ready, 0);
        chk("idle_err",   bus.cpu_err,   0);
        chk("idle_rdata", bus.cpu_rdata, 0);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        @(negedge cpu_clk);
        drive_junk_req();
        if (idx < 0) begin
            chk("miss_ready", bus.cpu_ready, 1);
            chk("miss_err",   bus.cpu_err,   1);
            chk("miss_rdata", bus.cpu_rdata, 0);
            chk("miss_sel",   bus.slv_sel,   0);
        end else begin
            own   = 4'b0001 << idx;
            n_acc = dly + 1;
            err_e = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            if (n_acc > TIMEOUT) begin
                n_acc = TIMEOUT;
                err_e = 1'b1;
            end
`endif
            for (int k = 0; k < n_acc; k++) begin
                chk("acc_sel",   bus.slv_sel,   own);
                chk("acc_we",    bus.slv_we,    we);
                chk("acc_addr",  bus.slv_addr,  a);
                chk("acc_wdata", bus.slv_wdata, wd);
                chk("acc_ready", bus.cpu_ready, 0);
                chk("acc_err",   bus.cpu_err,   0);
                chk("acc_rdata", bus.cpu_rdata, 0);
                bus.slv_rdata = {$urandom, $urandom, $urandom, $urandom};
                bus.slv_ack   = stray ? (4'($urandom) & ~own) : 4'b0000;
                if (k == dly) begin
                    bus.slv_ack[idx]              = 1'b1;
                    bus.slv_rdata[idx*32 +: 32]   = rd;
                end
                @(negedge cpu_clk);
                drive_junk_req();
            end
            bus.slv_ack = '0;
            chk("resp_ready", bus.cpu_ready, 1);
            chk("resp_err",   bus.cpu_err,   err_e);
            chk("resp_rdata", bus.cpu_rdata, (err_e || we) ? 32'h0 : rd);
            chk("resp_sel",   bus.slv_sel,   0);
        end
        @(negedge cpu_clk);
        bus.cpu_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_4000 | ($urandom & 32'h0000_3FFF);
            1:       return 32'hFFFF_F000 | ($urandom & 32'hF);
            2:       return 32'hFFFF_F070 | ($urandom & 32'hF);
            3:       return 32'hFFFF_F060 | ($urandom & 32'hF);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cpu_rst_n     = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.slv_rdata = '0;
        bus.slv_ack   = '0;
        repeat (2) @(negedge cpu_clk);
        chk("rst_ready", bus.cpu_ready, 0);
        chk("rst_err",   bus.cpu_err,   0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_sel",   bus.slv_sel,   0);
        chk("rst_addr",  bus.slv_addr,  0);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);

        txn(1'b0, 32'h0000_4008, 32'h0,  0, 32'h1234_5678, 1'b0);
        txn(1'b1, 32'hFFFF_F060, 32'hA5, 3, 32'hDEAD_BEEF, 1'b0);
        txn(1'b0, 32'h8000_0000, 32'h0,  0, 32'h0,         1'b0);
        txn(1'b0, 32'hFFFF_F074, 32'h0, 40, 32'hCAFE_F00D, 1'b1);
`ifdef BRIDGE_TIMEOUT_EN
        txn(1'b0, 32'hFFFF_F004, 32'h0,  14, 32'h5A5A_0001, 1'b0);
        txn(1'b0, 32'hFFFF_F004, 32'h0, 200, 32'h5A5A_0002, 1'b1);
`endif
        for (int n = 0; n < 60; n++)
            txn(1'($urandom_range(0, 1)), rand_addr(), $urandom,
                $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));

        // Reset mid-ACCESS, with a stray ack from slave 2 while slave 1 is selected.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'hFFFF_F004;
        @(negedge cpu_clk);
        bus.cpu_req = 1'b0;
        chk("rst_acc_sel", bus.slv_sel, 4'b0010);
        bus.slv_ack   = 4'b0100;
        bus.slv_rdata = {4{32'h7777_7777}};
        @(negedge cpu_clk);
        chk("stray_sel",   bus.slv_sel,   4'b0010);
        chk("stray_ready", bus.cpu_ready, 0);
        #2 cpu_rst_n = 1'b0;
        #1;
        chk("arst_sel",   bus.slv_sel,   0);
        chk("arst_ready", bus.cpu_ready, 0);
        chk("arst_addr",  bus.slv_addr,  0);
        bus.slv_ack = 4'b0010;
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge cpu_clk);
            chk("post_rst_ready", bus.cpu_ready, 0);
            chk("post_rst_sel",   bus.slv_sel,   0);
        end
        bus.slv_ack = '0;

        txn(1'b0, 32'h0000_7FFC, 32'h0, 1, 32'h0BAD_CAFE, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
